// File: rtl/fabosc_seq_pkg.sv
// ============================================================================
// Module      : fabosc_seq_pkg
// Description : Shared state encoding, constants and counter-width helpers for
//               the fabric-oscillator reset/tick sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fabosc_seq_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STRETCH   = 2'd1,
        ST_RUN       = 2'd2,
        ST_UNUSED    = 2'd3
    } state_t;

    localparam int US_PER_MS = 1000;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int filt_cnt_width(input int lock_filter);
        return cnt_width(lock_filter);
    endfunction

    function automatic int str_cnt_width(input int stretch_cycles);
        return cnt_width(stretch_cycles);
    endfunction

    function automatic int us_cnt_width(input int clk_freq_hz);
        return cnt_width(clk_freq_hz / 1000000);
    endfunction

    function automatic int ms_cnt_width();
        return cnt_width(US_PER_MS);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fabosc_tick_gen.sv
// ============================================================================
// Module      : fabosc_tick_gen
// Description : 1 us / 1 ms clock-enable dividers, active only while enabled;
//               optional heartbeat output when FABOSC_HEARTBEAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fabosc_tick_gen
    import fabosc_seq_pkg::*;
#(
    parameter int US_DIV = 50
`ifdef FABOSC_HEARTBEAT_EN
    ,
    parameter int HB_MS  = 500
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick_1us,
    output logic tick_1ms
`ifdef FABOSC_HEARTBEAT_EN
    ,
    output logic heartbeat
`endif
);

    localparam int UW = cnt_width(US_DIV);
    localparam int MW = ms_cnt_width();

    logic [UW-1:0] us_cnt;
    logic [MW-1:0] ms_cnt;
    logic          run_q;
    logic          counting;
    logic          us_wrap;
    logic          ms_wrap;

    // Counting starts the cycle after RUN entry, so the first tick lands
    // exactly US_DIV cycles after FAB_RESET_N rises.
    assign counting = enable && run_q;
    assign us_wrap  = (us_cnt == UW'(US_DIV - 1));
    assign ms_wrap  = (ms_cnt == MW'(US_PER_MS - 1));
    assign tick_1us = counting && us_wrap;
    assign tick_1ms = tick_1us && ms_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= 1'b0;
            us_cnt <= '0;
            ms_cnt <= '0;
        end else begin
            run_q <= enable;
            if (!enable) begin
                us_cnt <= '0;
                ms_cnt <= '0;
            end else if (counting) begin
                us_cnt <= us_wrap ? '0 : us_cnt + 1'b1;
                if (tick_1us) begin
                    ms_cnt <= ms_wrap ? '0 : ms_cnt + 1'b1;
                end
            end
        end
    end

`ifdef FABOSC_HEARTBEAT_EN
    localparam int HW = cnt_width(HB_MS);

    logic [HW-1:0] hb_cnt;
    logic          hb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_cnt <= '0;
            hb     <= 1'b0;
        end else if (!enable) begin
            hb_cnt <= '0;
            hb     <= 1'b0;
        end else if (tick_1ms) begin
            if (hb_cnt == HW'(HB_MS - 1)) begin
                hb_cnt <= '0;
                hb     <= ~hb;
            end else begin
                hb_cnt <= hb_cnt + 1'b1;
            end
        end
    end

    // Gated so the output drops on the same edge that leaves RUN.
    assign heartbeat = hb && enable;
`endif

endmodule

`default_nettype wire

// File: rtl/fabosc_reset_tick_sequencer.sv
// ============================================================================
// Module      : fabosc_reset_tick_sequencer
// Description : Qualifies CCC lock, sequences FAB_RESET_N and gates the shared
//               1 us / 1 ms ticks to RUN. Optional macro: FABOSC_HEARTBEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fabosc_reset_tick_sequencer
    import fabosc_seq_pkg::*;
#(
    parameter int CLK_FREQ_HZ    = 50000000,
    parameter int LOCK_FILTER    = 16,
    parameter int STRETCH_CYCLES = 1024
`ifdef FABOSC_HEARTBEAT_EN
    ,
    parameter int HB_MS          = 500
`endif
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       CCC_LOCK,
    input  logic       SW_RESET_REQ,
    output logic       FAB_RESET_N,
    output logic       READY,
    output logic       TICK_1US,
    output logic       TICK_1MS,
    output logic [1:0] STATE,
    output logic [7:0] LOCK_LOSS_CNT
`ifdef FABOSC_HEARTBEAT_EN
    ,
    output logic       HEARTBEAT
`endif
);

    localparam int FW     = filt_cnt_width(LOCK_FILTER);
    localparam int STW    = str_cnt_width(STRETCH_CYCLES);
    localparam int US_DIV = CLK_FREQ_HZ / 1000000;

    state_t          state;
    state_t          state_nx;
    logic            sync_ff;
    logic            lock_s;
    logic [FW-1:0]   filt_cnt;
    logic [FW-1:0]   filt_nx;
    logic [STW-1:0]  str_cnt;
    logic [STW-1:0]  str_nx;
    logic [7:0]      loss_cnt;
    logic [7:0]      loss_nx;
    logic            loss_inc;
    logic            fab_rst_n_q;
    logic            ready_q;
    logic            run_en;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            sync_ff     <= 1'b0;
            lock_s      <= 1'b0;
            state       <= ST_WAIT_LOCK;
            filt_cnt    <= '0;
            str_cnt     <= '0;
            loss_cnt    <= 8'd0;
            fab_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            sync_ff     <= CCC_LOCK;
            lock_s      <= sync_ff;
            state       <= state_nx;
            filt_cnt    <= filt_nx;
            str_cnt     <= str_nx;
            loss_cnt    <= loss_nx;
            fab_rst_n_q <= (state_nx == ST_RUN);
            ready_q     <= (state_nx == ST_RUN);
        end
    end

    // Lock loss outranks a software request so a coincident pair counts once.
    always_comb begin
        state_nx = state;
        filt_nx  = filt_cnt;
        str_nx   = str_cnt;
        loss_inc = 1'b0;
        case (state)
            ST_WAIT_LOCK: begin
                if (!lock_s || SW_RESET_REQ) begin
                    filt_nx = '0;
                end else if (filt_cnt == FW'(LOCK_FILTER - 1)) begin
                    state_nx = ST_STRETCH;
                    filt_nx  = '0;
                    str_nx   = '0;
                end else begin
                    filt_nx = filt_cnt + 1'b1;
                end
            end
            ST_STRETCH: begin
                if (!lock_s) begin
                    state_nx = ST_WAIT_LOCK;
                    loss_inc = 1'b1;
                end else if (SW_RESET_REQ) begin
                    state_nx = ST_WAIT_LOCK;
                end else if (str_cnt == STW'(STRETCH_CYCLES - 1)) begin
                    state_nx = ST_RUN;
                end else begin
                    str_nx = str_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_nx = ST_WAIT_LOCK;
                    loss_inc = 1'b1;
                end else if (SW_RESET_REQ) begin
                    state_nx = ST_WAIT_LOCK;
                end
            end
            default: begin
                state_nx = ST_WAIT_LOCK;
                filt_nx  = '0;
            end
        endcase
        loss_nx = (loss_inc && (loss_cnt != 8'hFF)) ? loss_cnt + 8'd1 : loss_cnt;
    end

    assign run_en        = (state == ST_RUN);
    assign FAB_RESET_N   = fab_rst_n_q;
    assign READY         = ready_q;
    assign STATE         = state;
    assign LOCK_LOSS_CNT = loss_cnt;

    fabosc_tick_gen #(
        .US_DIV    (US_DIV)
`ifdef FABOSC_HEARTBEAT_EN
        ,
        .HB_MS     (HB_MS)
`endif
    ) u_tick_gen (
        .clk       (CLK),
        .rst_n     (RESETN),
        .enable    (run_en),
        .tick_1us  (TICK_1US),
        .tick_1ms  (TICK_1MS)
`ifdef FABOSC_HEARTBEAT_EN
        ,
        .heartbeat (HEARTBEAT)
`endif
    );

endmodule

`default_nettype wire

// File: tb/tb_fabosc_reset_tick_sequencer.sv
// ============================================================================
// Module      : tb_fabosc_reset_tick_sequencer
// Description : Self-checking bench for fabosc_reset_tick_sequencer against a
//               time-based reference model; honours FABOSC_HEARTBEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fabosc_reset_tick_sequencer;

    localparam int CLK_HZ = 50000000;
    localparam int LF     = 4;
    localparam int SC     = 8;
    localparam int US_DIV = CLK_HZ / 1000000;
    localparam int MS_DIV = US_DIV * 1000;
`ifdef FABOSC_HEARTBEAT_EN
    localparam int HB     = 2;
`endif

    logic       CLK = 1'b0;
    logic       RESETN = 1'b0;
    logic       CCC_LOCK = 1'b0;
    logic       SW_RESET_REQ = 1'b0;
    logic       FAB_RESET_N;
    logic       READY;
    logic       TICK_1US;
    logic       TICK_1MS;
    logic [1:0] STATE;
    logic [7:0] LOCK_LOSS_CNT;
`ifdef FABOSC_HEARTBEAT_EN
    logic       HEARTBEAT;
`endif

    int checks = 0;
    int errors = 0;

    always #10 CLK = ~CLK;

    fabosc_reset_tick_sequencer #(
        .CLK_FREQ_HZ    (CLK_HZ),
        .LOCK_FILTER    (LF),
        .STRETCH_CYCLES (SC)
`ifdef FABOSC_HEARTBEAT_EN
        ,
        .HB_MS          (HB)
`endif
    ) dut (
        .CLK           (CLK),
        .RESETN        (RESETN),
        .CCC_LOCK      (CCC_LOCK),
        .SW_RESET_REQ  (SW_RESET_REQ),
        .FAB_RESET_N   (FAB_RESET_N),
        .READY         (READY),
        .TICK_1US      (TICK_1US),
        .TICK_1MS      (TICK_1MS),
        .STATE         (STATE),
        .LOCK_LOSS_CNT (LOCK_LOSS_CNT)
`ifdef FABOSC_HEARTBEAT_EN
        ,
        .HEARTBEAT     (HEARTBEAT)
`endif
    );

    // Reference model: mode 0/1/2 = waiting, stretching, running. Timing is
    // tracked as absolute edge numbers; ticks come from elapsed time in RUN.
    typedef struct {
        int mode;
        int streak;
        int loss;
        int sstart;
        int rstart;
    } mstate_t;

    mstate_t m = '{0, 0, 0, 0, 0};
    int      m_cyc = 0;
    logic    m_h0 = 1'b0;
    logic    m_h1 = 1'b0;

    function automatic mstate_t step(input mstate_t s, input logic ls, input logic sw, input int c);
        mstate_t r = s;
        if (s.mode == 0) begin
            if (ls && !sw) begin
                if (s.streak == LF - 1) begin
                    r.mode   = 1;
                    r.sstart = c;
                    r.streak = 0;
                end else begin
                    r.streak = s.streak + 1;
                end
            end else begin
                r.streak = 0;
            end
        end else begin
            if (!ls) begin
                r.mode = 0;
                r.loss = (s.loss < 255) ? s.loss + 1 : 255;
            end else if (sw) begin
                r.mode = 0;
            end else if (s.mode == 1 && (c - s.sstart) == SC) begin
                r.mode   = 2;
                r.rstart = c;
            end
            if (r.mode == 0) r.streak = 0;
        end
        return r;
    endfunction

    always @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            m     <= '{0, 0, 0, 0, 0};
            m_cyc <= 0;
            m_h0  <= 1'b0;
            m_h1  <= 1'b0;
        end else begin
            m     <= step(m, m_h1, SW_RESET_REQ, m_cyc + 1);
            m_cyc <= m_cyc + 1;
            m_h0  <= CCC_LOCK;
            m_h1  <= m_h0;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge CLK) begin
        int   el;
        logic run, e_us, e_ms, e_hb;
        run  = (m.mode == 2);
        el   = m_cyc - m.rstart;
        e_us = run && el > 0 && (el % US_DIV) == 0;
        e_ms = run && el > 0 && (el % MS_DIV) == 0;
        e_hb = 1'b0;
`ifdef FABOSC_HEARTBEAT_EN
        e_hb = run && el > 0 && (((el - 1) / (MS_DIV * HB)) % 2) == 1;
`endif
        checks++;
        if (FAB_RESET_N !== run || READY !== run || TICK_1US !== e_us || TICK_1MS !== e_ms
            || int'(STATE) != m.mode || int'(LOCK_LOSS_CNT) != m.loss
`ifdef FABOSC_HEARTBEAT_EN
            || HEARTBEAT !== e_hb
`endif
            ) begin
            errors++;
            $display("FAIL cycle_compare t=%0t got fab=%b rdy=%b us=%b ms=%b st=%0d loss=%0d, expected fab=%b rdy=%b us=%b ms=%b st=%0d loss=%0d hb=%b",
                     $time, FAB_RESET_N, READY, TICK_1US, TICK_1MS, STATE, LOCK_LOSS_CNT,
                     run, run, e_us, e_ms, m.mode, m.loss, e_hb);
        end
    end

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check_int({name, "_state"}, int'(STATE), 0);
        check_int({name, "_fab_reset_n"}, int'(FAB_RESET_N), 0);
        check_int({name, "_ready"}, int'(READY), 0);
        check_int({name, "_tick_1us"}, int'(TICK_1US), 0);
        check_int({name, "_tick_1ms"}, int'(TICK_1MS), 0);
        check_int({name, "_loss_cnt"}, int'(LOCK_LOSS_CNT), 0);
    endtask

    // Edges until STATE reaches st, counted from the current negedge; -1 on timeout.
    task automatic wait_state(input logic [1:0] st, input int max_cyc, output int n);
        n = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge CLK);
            if (STATE == st) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_us_tick(input int max_cyc, output int n);
        n = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge CLK);
            if (TICK_1US) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int n_us, n_ms, n_orphan, first_us;

        repeat (3) @(negedge CLK);
        check_reset_outputs("reset");
        RESETN = 1'b1;
        repeat (10) @(negedge CLK);

        // Clean lock
        CCC_LOCK = 1'b1;
        wait_state(2'd1, 50, n);
        check_int("clean_lock_to_stretch", n, 6);
        wait_state(2'd2, 50, n);
        check_int("stretch_to_run", n, SC);
        check_int("run_fab_reset_n", int'(FAB_RESET_N), 1);
        check_int("run_ready", int'(READY), 1);

        // Tick cadence over 1.05 ms from RUN entry
        n_us = 0; n_ms = 0; n_orphan = 0; first_us = -1;
        for (int i = 1; i <= 52500; i++) begin
            @(negedge CLK);
            if (TICK_1US) begin
                n_us++;
                if (first_us < 0) first_us = i;
            end
            if (TICK_1MS) begin
                n_ms++;
                if (!TICK_1US) n_orphan++;
            end
        end
        check_int("first_tick_1us_offset", first_us, 50);
        check_int("tick_1us_count", n_us, 1050);
        check_int("tick_1ms_count", n_ms, 1);
        check_int("tick_1ms_without_1us", n_orphan, 0);

        // Lock loss in RUN
        CCC_LOCK = 1'b0;
        n = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge CLK);
            if (!FAB_RESET_N) begin
                n = i;
                break;
            end
        end
        check_int("lock_loss_latency", n, 3);
        check_int("lock_loss_cnt_1", int'(LOCK_LOSS_CNT), 1);
        check_int("lock_loss_tick_stopped", int'(TICK_1US), 0);
        repeat (3) @(negedge CLK);

        // Re-lock
        CCC_LOCK = 1'b1;
        wait_state(2'd2, 100, n);
        check_int("relock_to_run", n, 14);
        wait_us_tick(200, n);
        check_int("relock_first_tick", n, 50);

        // Software request alone in RUN
        SW_RESET_REQ = 1'b1;
        @(negedge CLK);
        SW_RESET_REQ = 1'b0;
        check_int("sw_req_state", int'(STATE), 0);
        check_int("sw_req_loss_unchanged", int'(LOCK_LOSS_CNT), 1);
        wait_state(2'd2, 100, n);
        check_int("sw_req_requalify_run", n, LF + SC);

        // Software request coincident with lock_s falling
        CCC_LOCK = 1'b0;
        repeat (2) @(negedge CLK);
        SW_RESET_REQ = 1'b1;
        @(negedge CLK);
        SW_RESET_REQ = 1'b0;
        check_int("sw_and_loss_state", int'(STATE), 0);
        check_int("sw_and_loss_cnt", int'(LOCK_LOSS_CNT), 2);

        // Asynchronous reset mid-STRETCH
        CCC_LOCK = 1'b1;
        wait_state(2'd1, 50, n);
        repeat (2) @(negedge CLK);
        #5 RESETN = 1'b0;
        #1 check_reset_outputs("async_stretch");
        @(negedge CLK);
        RESETN = 1'b1;
        wait_state(2'd2, 100, n);
        check_int("post_reset_run", n, 14);

        // Asynchronous reset mid-RUN
        repeat (20) @(negedge CLK);
        #5 RESETN = 1'b0;
        #1 check_reset_outputs("async_run");
        @(negedge CLK);
        RESETN = 1'b1;
        CCC_LOCK = 1'b0;
        repeat (4) @(negedge CLK);

        // Saturation after 300 lock losses
        for (int k = 0; k < 300; k++) begin
            CCC_LOCK = 1'b1;
            repeat (7) @(negedge CLK);
            CCC_LOCK = 1'b0;
            repeat (4) @(negedge CLK);
        end
        check_int("loss_cnt_saturated", int'(LOCK_LOSS_CNT), 255);

        // Randomized lock activity and software requests
        for (int seg = 0; seg < 60; seg++) begin
            int hold;
            CCC_LOCK = ($urandom_range(0, 9) < 7);
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(60, 200) : $urandom_range(1, 20);
            for (int c = 0; c < hold; c++) begin
                SW_RESET_REQ = ($urandom_range(0, 59) == 0);
                @(negedge CLK);
            end
            SW_RESET_REQ = 1'b0;
        end

`ifdef FABOSC_HEARTBEAT_EN
        // Heartbeat: long RUN stretch so the model sees a toggle
        CCC_LOCK = 1'b1;
        wait_state(2'd2, 100, n);
        repeat (2 * MS_DIV * HB + 100) @(negedge CLK);
`endif

        repeat (5) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
